tage_tagged_bank: RTL and testbench
===================================

TAGE_TAGGED_BANK -- requirements
Module: tage_tagged_bank

Interface
REQ-001 SHALL have parameter IDX_W, default 10, index width; table depth = 2**IDX_W entries.
REQ-002 SHALL have parameter TAG_W, default 8, partial-tag width.
REQ-003 SHALL have parameter CTR_W, default 3, prediction counter width.
REQ-004 SHALL have parameter U_W, default 2, useful counter width.
REQ-005 SHALL have parameter EPOCH, default 1024, accepted updates per aging epoch.
REQ-006 SHALL have ports, clock and reset first:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low
- lk_valid  in  1  lookup request
- lk_idx  in  IDX_W  lookup index
- lk_tag  in  TAG_W  lookup tag
- lk_rvalid  out  1  lookup result valid
- lk_hit  out  1  entry valid and tag match
- lk_pred  out  1  counter MSB (taken)
- lk_weak  out  1  counter is 2**(CTR_W-1) or 2**(CTR_W-1)-1
- lk_u  out  U_W  useful counter of the hit entry, 0 on miss
- up_valid  in  1  update request
- up_ready  out  1  update accepted when up_valid && up_ready
- up_idx  in  IDX_W  update index
- up_tag  in  TAG_W  update tag
- up_taken  in  1  resolved direction
- up_alloc  in  1  allocate entry instead of train
- up_uinc  in  1  useful increment
- up_udec  in  1  useful decrement
- busy  out  1  aging sweep in progress

Function
REQ-007 SHALL store per entry {valid, tag, ctr, u}.
REQ-008 SHALL return a lookup 2 cycles after acceptance (stage 1: read; stage 2: compare, register outputs); one lookup per cycle, fully pipelined, never stalled.
REQ-009 SHALL drive lk_hit/lk_pred/lk_weak/lk_u to 0 whenever lk_rvalid is 0.
REQ-010 SHALL, on an accepted update with up_alloc=1, write valid=1, tag=up_tag, u=0, ctr=2**(CTR_W-1) if up_taken, else 2**(CTR_W-1)-1, regardless of prior contents.
REQ-011 SHALL, on an accepted update with up_alloc=0 and a valid tag-matching entry, saturate ctr +1 if taken else -1; saturate u +1 if only up_uinc, -1 if only up_udec, unchanged if both or neither.
REQ-012 SHALL leave the entry unchanged on an accepted non-alloc update that misses.
REQ-013 SHALL commit an update at the clock edge following acceptance.
REQ-014 SHALL return pre-update contents to a lookup whose stage-1 read coincides with the update write to the same index (read-before-write); the next lookup SHALL see the new contents.
REQ-015 SHALL implement FSM IDLE/SWEEP: IDLE counts accepted updates; on the EPOCH-th accepted update, go to SWEEP, clear the count, and hold busy=1, up_ready=0.
REQ-016 SHALL, in SWEEP, shift right u of entry 0..2**IDX_W-1, one entry per cycle, then return to IDLE; lookups continue during SWEEP.
REQ-017 SHALL let a swept entry's lookup in the same cycle see pre-shift u.
REQ-018 SHALL drop up_valid while up_ready=0; the requester holds the request.

Reset
REQ-019 SHALL asynchronously clear all valid bits, pipeline valids, FSM to IDLE, and the epoch count; lk_* outputs 0, busy 0, up_ready 1.
REQ-020 SHALL abort a sweep in progress when reset asserts; tag/ctr/u need no reset.

Configuration
REQ-021 SHALL compile aging with TAGE_U_AGING_EN defined (REQ-015..017 apply).
REQ-022 SHALL, with TAGE_U_AGING_EN undefined, omit the counter and FSM: up_ready tied 1, busy tied 0, u only changes via updates.

Structure
REQ-023 SHALL place the entry struct typedef, the weak-taken/weak-not-taken init functions and the FSM state enum in package tage_pkg.
REQ-024 SHALL instantiate sub-module tage_sat_ctr (parametrised width, inc/dec, saturating) for ctr and u arithmetic.

Verification (IDX_W=4, TAG_W=8, CTR_W=3, U_W=2, EPOCH=8)
REQ-025 Reset, lookup idx 3 tag 0x5A -> lk_rvalid=1 at cycle+2, lk_hit=0, lk_u=0.
REQ-026 Alloc idx 3 tag 0x5A taken, then lookup -> hit=1, pred=1, weak=1 (ctr=4); three taken updates -> ctr=7, fourth stays 7.
REQ-027 Update idx 3 with tag 0x5B -> entry unchanged; lookup of tag 0x5B -> hit=0.
REQ-028 Same-cycle lookup read and update of idx 3 -> lookup returns old ctr; next lookup returns new.
REQ-029 u=3 at idx 3, eighth accepted update -> busy=1, up_ready=0 for 16 cycles, then u=1; held update accepted after.
REQ-030 Reset asserted mid-sweep -> busy=0, up_ready=1 immediately, all lookups miss.

Source files
------------

// File: rtl/tage_pkg.sv
// Shared types and helpers for the TAGE tagged bank.
// Entry fields are sized to the widest supported config; the bank uses the low bits.
package tage_pkg;

    localparam int TAG_MAX_W = 16;
    localparam int CTR_MAX_W = 8;
    localparam int U_MAX_W   = 8;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [CTR_MAX_W-1:0] ctr;
        logic [U_MAX_W-1:0]   u;
    } tage_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } tage_state_t;

    function automatic logic [CTR_MAX_W-1:0] ctr_weak_taken(input int w);
        return CTR_MAX_W'(1) << (w - 1);
    endfunction

    function automatic logic [CTR_MAX_W-1:0] ctr_weak_not_taken(input int w);
        return (CTR_MAX_W'(1) << (w - 1)) - CTR_MAX_W'(1);
    endfunction

endpackage

// File: rtl/tage_sat_ctr.sv
// Saturating up/down counter step; simultaneous inc and dec cancel out.
module tage_sat_ctr #(
    parameter int W = 3
) (
    input  logic [W-1:0] val_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] res_o
);

    localparam logic [W-1:0] MAX = '1;

    always_comb begin
        res_o = val_i;
        if (inc_i && !dec_i && (val_i != MAX)) begin
            res_o = val_i + W'(1);
        end else if (dec_i && !inc_i && (val_i != '0)) begin
            res_o = val_i - W'(1);
        end
    end

endmodule

// File: rtl/tage_tagged_bank.sv
// One TAGE tagged table: 2-stage lookup pipeline, single-cycle update, optional u aging.
// Define TAGE_U_AGING_EN to build the epoch counter and IDLE/SWEEP useful-bit aging.
module tage_tagged_bank
    import tage_pkg::*;
#(
    parameter int IDX_W = 10,
    parameter int TAG_W = 8,
    parameter int CTR_W = 3,
    parameter int U_W   = 2,
    parameter int EPOCH = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lk_valid,
    input  logic [IDX_W-1:0] lk_idx,
    input  logic [TAG_W-1:0] lk_tag,
    output logic             lk_rvalid,
    output logic             lk_hit,
    output logic             lk_pred,
    output logic             lk_weak,
    output logic [U_W-1:0]   lk_u,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [IDX_W-1:0] up_idx,
    input  logic [TAG_W-1:0] up_tag,
    input  logic             up_taken,
    input  logic             up_alloc,
    input  logic             up_uinc,
    input  logic             up_udec,
    output logic             busy
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_weak_taken(CTR_W));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_weak_not_taken(CTR_W));

    tage_entry_t tbl_q [DEPTH];

    logic             up_fire;
    logic             sweep_en;
    logic [IDX_W-1:0] sweep_idx;

    // Update: read-modify-write of the addressed entry, committed at the accepting edge
    tage_entry_t    up_ent;
    tage_entry_t    up_ent_d;
    logic           up_hit;
    logic [CTR_W-1:0] up_ctr_nxt;
    logic [U_W-1:0]   up_u_nxt;

    assign up_ent  = tbl_q[up_idx];
    assign up_fire = up_valid && up_ready;
    assign up_hit  = up_ent.valid && (up_ent.tag == TAG_MAX_W'(up_tag));

    tage_sat_ctr #(.W(CTR_W)) u_ctr_step (
        .val_i (CTR_W'(up_ent.ctr)),
        .inc_i (up_taken),
        .dec_i (!up_taken),
        .res_o (up_ctr_nxt)
    );

    tage_sat_ctr #(.W(U_W)) u_u_step (
        .val_i (U_W'(up_ent.u)),
        .inc_i (up_uinc),
        .dec_i (up_udec),
        .res_o (up_u_nxt)
    );

    always_comb begin
        up_ent_d = up_ent;
        if (up_alloc) begin
            up_ent_d.valid = 1'b1;
            up_ent_d.tag   = TAG_MAX_W'(up_tag);
            up_ent_d.u     = '0;
            up_ent_d.ctr   = up_taken ? CTR_MAX_W'(CTR_WT) : CTR_MAX_W'(CTR_WNT);
        end else if (up_hit) begin
            up_ent_d.ctr = CTR_MAX_W'(up_ctr_nxt);
            up_ent_d.u   = U_MAX_W'(up_u_nxt);
        end
    end

    // Only valid bits are reset; tag/ctr/u are don't-care until allocated
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i].valid <= 1'b0;
            end
        end else begin
            if (up_fire) begin
                tbl_q[up_idx] <= up_ent_d;
            end
            if (sweep_en) begin
                tbl_q[sweep_idx].u <= tbl_q[sweep_idx].u >> 1;
            end
        end
    end

    // Stage 1: array read (sees contents before this edge's write/shift)
    logic        lk_vld_p1_q;
    tage_entry_t lk_ent_p1_q;
    logic [TAG_W-1:0] lk_tag_p1_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lk_vld_p1_q <= 1'b0;
        end else begin
            lk_vld_p1_q <= lk_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (lk_valid) begin
            lk_ent_p1_q <= tbl_q[lk_idx];
            lk_tag_p1_q <= lk_tag;
        end
    end

    // Stage 2: tag compare, registered outputs
    logic             hit_p1;
    logic [CTR_W-1:0] ctr_p1;

    assign hit_p1 = lk_vld_p1_q && lk_ent_p1_q.valid
                    && (lk_ent_p1_q.tag == TAG_MAX_W'(lk_tag_p1_q));
    assign ctr_p1 = CTR_W'(lk_ent_p1_q.ctr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lk_rvalid <= 1'b0;
            lk_hit    <= 1'b0;
            lk_pred   <= 1'b0;
            lk_weak   <= 1'b0;
            lk_u      <= '0;
        end else begin
            lk_rvalid <= lk_vld_p1_q;
            lk_hit    <= hit_p1;
            lk_pred   <= hit_p1 && ctr_p1[CTR_W-1];
            lk_weak   <= hit_p1 && ((ctr_p1 == CTR_WT) || (ctr_p1 == CTR_WNT));
            lk_u      <= hit_p1 ? U_W'(lk_ent_p1_q.u) : '0;
        end
    end

`ifdef TAGE_U_AGING_EN
    localparam int CNT_W = $clog2(EPOCH + 1);

    tage_state_t      state_q;
    logic [CNT_W-1:0] epoch_cnt_q;
    logic [IDX_W-1:0] sweep_idx_q;
    logic             busy_q;
    logic             ready_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            epoch_cnt_q <= '0;
            sweep_idx_q <= '0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (up_fire) begin
                        if (epoch_cnt_q == CNT_W'(EPOCH - 1)) begin
                            state_q     <= ST_SWEEP;
                            epoch_cnt_q <= '0;
                            sweep_idx_q <= '0;
                            busy_q      <= 1'b1;
                            ready_q     <= 1'b0;
                        end else begin
                            epoch_cnt_q <= epoch_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_SWEEP: begin
                    if (sweep_idx_q == '1) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        sweep_idx_q <= sweep_idx_q + IDX_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sweep_en  = (state_q == ST_SWEEP);
    assign sweep_idx = sweep_idx_q;
    assign busy      = busy_q;
    assign up_ready  = ready_q;
`else
    assign sweep_en  = 1'b0;
    assign sweep_idx = '0;
    assign busy      = 1'b0;
    assign up_ready  = 1'b1;
`endif

endmodule

// File: tb/tb_tage_tagged_bank.sv
// Randomized + directed bench for tage_tagged_bank against an entry-level behavioural model.
// Aging scenarios run only when TAGE_U_AGING_EN is defined.
module tb_tage_tagged_bank;

    localparam int IDX_W = 4;
    localparam int TAG_W = 8;
    localparam int CTR_W = 3;
    localparam int U_W   = 2;
    localparam int EPOCH = 8;
    localparam int DEPTH = 16;
    localparam int CTR_MAX = 7;
    localparam int U_MAX   = 3;
`ifdef TAGE_U_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             lk_valid = 1'b0;
    logic [IDX_W-1:0] lk_idx = '0;
    logic [TAG_W-1:0] lk_tag = '0;
    logic             lk_rvalid, lk_hit, lk_pred, lk_weak;
    logic [U_W-1:0]   lk_u;
    logic             up_valid = 1'b0;
    logic             up_ready;
    logic [IDX_W-1:0] up_idx = '0;
    logic [TAG_W-1:0] up_tag = '0;
    logic             up_taken = 1'b0, up_alloc = 1'b0, up_uinc = 1'b0, up_udec = 1'b0;
    logic             busy;

    always #5 clk = ~clk;

    tage_tagged_bank #(
        .IDX_W(IDX_W), .TAG_W(TAG_W), .CTR_W(CTR_W), .U_W(U_W), .EPOCH(EPOCH)
    ) dut (
        .clk(clk), .reset(reset),
        .lk_valid(lk_valid), .lk_idx(lk_idx), .lk_tag(lk_tag),
        .lk_rvalid(lk_rvalid), .lk_hit(lk_hit), .lk_pred(lk_pred), .lk_weak(lk_weak), .lk_u(lk_u),
        .up_valid(up_valid), .up_ready(up_ready), .up_idx(up_idx), .up_tag(up_tag),
        .up_taken(up_taken), .up_alloc(up_alloc), .up_uinc(up_uinc), .up_udec(up_udec),
        .busy(busy)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: table contents, epoch count, sweep position (-1 = not sweeping)
    bit m_valid [DEPTH];
    int m_tag [DEPTH];
    int m_ctr [DEPTH];
    int m_u   [DEPTH];
    int m_cnt = 0;
    int m_sweep = -1;
    int pipe1 = 0;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_cnt = 0;
        m_sweep = -1;
        pipe1 = 0;
    endtask

    // Result word {rvalid, hit, pred, weak, u[1:0]}
    function automatic int model_lookup(input int idx, input int tag);
        int c;
        if (!(m_valid[idx] && m_tag[idx] == tag)) return 32;
        c = m_ctr[idx];
        return 32 + 16 + ((c >= 4) ? 8 : 0) + ((c == 4 || c == 3) ? 4 : 0) + m_u[idx];
    endfunction

    task automatic model_update(input int idx, input int tag, input bit tk, input bit al,
                                input bit inc, input bit dec);
        if (al) begin
            m_valid[idx] = 1'b1;
            m_tag[idx] = tag;
            m_u[idx] = 0;
            m_ctr[idx] = tk ? 4 : 3;
        end else if (m_valid[idx] && m_tag[idx] == tag) begin
            if (tk) m_ctr[idx] = (m_ctr[idx] == CTR_MAX) ? CTR_MAX : m_ctr[idx] + 1;
            else    m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
            if (inc && !dec) m_u[idx] = (m_u[idx] == U_MAX) ? U_MAX : m_u[idx] + 1;
            if (dec && !inc) m_u[idx] = (m_u[idx] == 0) ? 0 : m_u[idx] - 1;
        end
    endtask

    // One clock: advance the model with the currently driven inputs, then compare
    task automatic step();
        int exp_lk;
        exp_lk = pipe1;
        pipe1 = lk_valid ? model_lookup(int'(lk_idx), int'(lk_tag)) : 0;
        if (m_sweep >= 0) begin
            m_u[m_sweep] = m_u[m_sweep] / 2;
            m_sweep++;
            if (m_sweep == DEPTH) m_sweep = -1;
        end else if (up_valid) begin
            model_update(int'(up_idx), int'(up_tag), up_taken, up_alloc, up_uinc, up_udec);
            if (AGING) begin
                m_cnt++;
                if (m_cnt == EPOCH) begin
                    m_cnt = 0;
                    m_sweep = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        check_eq("lk", {26'd0, lk_rvalid, lk_hit, lk_pred, lk_weak, lk_u}, exp_lk);
        check_eq("hs", {30'd0, up_ready, busy}, (m_sweep < 0) ? 2 : 1);
    endtask

    task automatic drive(input bit lv, input int li, input int lt,
                         input bit uv, input int ui, input int ut,
                         input bit tk, input bit al, input bit inc, input bit dec);
        lk_valid = lv;  lk_idx = IDX_W'(li);  lk_tag = TAG_W'(lt);
        up_valid = uv;  up_idx = IDX_W'(ui);  up_tag = TAG_W'(ut);
        up_taken = tk;  up_alloc = al;  up_uinc = inc;  up_udec = dec;
        step();
    endtask

    task automatic lookup(input int li, input int lt);
        drive(1, li, lt, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic update(input int ui, input int ut, input bit tk, input bit al,
                          input bit inc, input bit dec);
        drive(0, 0, 0, 1, ui, ut, tk, al, inc, dec);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int k;
        int tags [3];
        tags[0] = 'h5A; tags[1] = 'h5B; tags[2] = 'h33;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_lk", {26'd0, lk_rvalid, lk_hit, lk_pred, lk_weak, lk_u}, 0);
        check_eq("rst_hs", {30'd0, up_ready, busy}, 2);
        reset = 1'b1;

        // Miss after reset with two-cycle latency
        lookup(3, 'h5A);
        check_eq("r25_lat1", {31'd0, lk_rvalid}, 0);
        idle();
        check_eq("r25_res", {28'd0, lk_rvalid, lk_hit, lk_u}, 4'b1000);

        // Allocation, training, saturation
        update(3, 'h5A, 1, 1, 0, 0);
        lookup(3, 'h5A);
        idle();
        check_eq("r26_alloc", {29'd0, lk_hit, lk_pred, lk_weak}, 3'b111);
        repeat (3) update(3, 'h5A, 1, 0, 0, 0);
        lookup(3, 'h5A);
        idle();
        check_eq("r26_strong", {29'd0, lk_hit, lk_pred, lk_weak}, 3'b110);
        update(3, 'h5A, 1, 0, 0, 0);
        update(3, 'h5A, 0, 0, 0, 0);
        lookup(3, 'h5A);
        idle();
        check_eq("r26_sat", {29'd0, lk_hit, lk_pred, lk_weak}, 3'b110);

        // Non-matching update leaves the entry alone
        update(3, 'h5B, 0, 0, 1, 0);
        lookup(3, 'h5B);
        lookup(3, 'h5A);
        check_eq("r27_miss", {31'd0, lk_hit}, 0);
        idle();
        check_eq("r27_keep", {28'd0, lk_hit, lk_u, lk_weak}, 4'b1000);

        // Read-before-write on a same-cycle lookup/update
        drive(1, 3, 'h5A, 1, 3, 'h5A, 0, 1, 0, 0);
        lookup(3, 'h5A);
        check_eq("r28_old", {29'd0, lk_hit, lk_pred, lk_weak}, 3'b110);
        idle();
        check_eq("r28_new", {29'd0, lk_hit, lk_pred, lk_weak}, 3'b101);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), tags[$urandom_range(0, 2)],
                  $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), tags[$urandom_range(0, 2)],
                  $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 1), $urandom_range(0, 1));
        end
        repeat (20) idle();

        if (AGING) begin
            reset = 1'b0;
            model_reset();
            @(posedge clk);
            #1;
            reset = 1'b1;

            // Epoch rollover sweeps u; held request waits out busy
            update(3, 'h5A, 1, 1, 0, 0);
            repeat (3) update(3, 'h5A, 1, 0, 1, 0);
            repeat (3) update(7, 'h21, 0, 1, 0, 0);
            lookup(3, 'h5A);
            idle();
            check_eq("r29_u3", {30'd0, lk_u}, 3);
            update(7, 'h21, 0, 1, 0, 0);
            check_eq("r29_busy", {30'd0, up_ready, busy}, 1);
            k = 0;
            while (busy && k < 40) begin
                k++;
                update(5, 'h11, 1, 1, 0, 0);
            end
            check_eq("r29_busy_len", k, 16);
            update(5, 'h11, 1, 1, 0, 0);
            lookup(3, 'h5A);
            lookup(5, 'h11);
            check_eq("r29_u1", {29'd0, lk_hit, lk_u}, 3'b101);
            idle();
            check_eq("r29_held", {31'd0, lk_hit}, 1);

            // Reset during a sweep aborts it
            repeat (7) update(9, 'h44, 0, 1, 0, 0);
            repeat (4) idle();
            check_eq("r30_pre", {31'd0, busy}, 1);
            #2;
            reset = 1'b0;
            #1;
            check_eq("r30_hs", {30'd0, up_ready, busy}, 2);
            check_eq("r30_lk", {31'd0, lk_rvalid}, 0);
            model_reset();
            @(posedge clk);
            #1;
            reset = 1'b1;
            lookup(3, 'h5A);
            lookup(5, 'h11);
            check_eq("r30_miss0", {30'd0, lk_rvalid, lk_hit}, 2'b10);
            idle();
            check_eq("r30_miss1", {30'd0, lk_rvalid, lk_hit}, 2'b10);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
